// File: rtl/led_key_pattern_ctrl_if.sv
// led_key_pattern_ctrl_if: key pins in, LED bank and status out
interface led_key_pattern_ctrl_if #(parameter int N_LEDS = 4);
  logic [3:0]        key_in;
  logic [N_LEDS-1:0] led_out;
  logic [1:0]        mode;
  logic [1:0]        speed;
  logic              paused;
  logic [3:0]        key_pulse;
  modport master (output key_in, input led_out, mode, speed, paused, key_pulse);
  modport slave  (input key_in, output led_out, mode, speed, paused, key_pulse);
endinterface

// File: rtl/led_key_pattern_ctrl.sv
// led_key_pattern_ctrl: debounced four-key control of an animated LED bank
module led_key_pattern_ctrl #(
  parameter int N_LEDS         = 4,
  parameter int DEB_CYCLES     = 1000000,
  parameter int STEP_CYCLES    = 12500000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LED_ACTIVE_LOW = 0
) (
  input logic clk,
  input logic rst,
  led_key_pattern_ctrl_if.slave bus
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [3:0] KPOL = {4{KEY_ACTIVE_LOW != 0}};
  localparam logic [N_LEDS-1:0] LPOL = {N_LEDS{LED_ACTIVE_LOW != 0}};
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
  logic [3:0] s1, s2, deb, kp;
  logic [CW-1:0] dcnt [4];
  logic [1:0] mode, speed, mode_n, spd_n;
  logic paused, up, dn, tick, spd_chg;
  logic [SW-1:0] scnt;
  logic [31:0] per;
  logic [N_LEDS-1:0] pat, led, reload, stepped;
  // Two-stage synchroniser; polarity is folded in first so an idle key reads 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.key_in ^ KPOL;
      s2 <= s1;
    end
  // Per-key debounce: accept a level held DEB_CYCLES cycles, pulse on press only
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      deb <= '0;
      kp  <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        kp[i] <= 1'b0;
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
          kp[i]   <= s2[i];
        end else dcnt[i] <= dcnt[i] + CW'(1);
      end
    end
  // Next-state decode for mode, speed, step timer and pattern
  always_comb begin
    mode_n  = mode + 2'd1;
    up      = kp[1] & ~kp[2];
    dn      = kp[2] & ~kp[1];
    spd_n   = (up && speed != 2'd3) ? speed + 2'd1 : (dn && speed != 2'd0) ? speed - 2'd1 : speed;
    spd_chg = spd_n != speed;
    per     = 32'(STEP_CYCLES) >> speed;
    tick    = scnt == SW'(per - 32'd1);
    reload  = mode_n == 2'd3 ? '1 : ONE;
    stepped = mode == 2'd1 ? {pat[N_LEDS-2:0], pat[N_LEDS-1]} :
              mode == 2'd2 ? {pat[0], pat[N_LEDS-1:1]} :
              mode == 2'd3 ? ~pat : pat;
  end
  // Control registers, step timer, pattern and registered LED drive
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode   <= 2'd0;
      speed  <= 2'd0;
      paused <= 1'b0;
      scnt   <= '0;
      pat    <= ONE;
      led    <= ONE ^ LPOL;
    end else begin
      if (kp[0]) mode <= mode_n;
      speed <= spd_n;
      if (kp[3]) paused <= ~paused;
      if (kp[0] || spd_chg) scnt <= '0;
      else if (!paused) scnt <= tick ? '0 : scnt + SW'(1);
      if (kp[0]) pat <= reload;
      else if (tick && !paused) pat <= stepped;
      led <= pat ^ LPOL;
    end
  assign bus.led_out   = led;
  assign bus.mode      = mode;
  assign bus.speed     = speed;
  assign bus.paused    = paused;
  assign bus.key_pulse = kp;
endmodule

// File: tb/tb_led_key_pattern_ctrl.sv
// tb_led_key_pattern_ctrl: directed checks of debounce, animation modes, speed, pause and reset
module tb_led_key_pattern_ctrl;
  logic clk, rst;
  int errors = 0, checks = 0, pcnt = 0;
  led_key_pattern_ctrl_if #(.N_LEDS(4)) bus();
  led_key_pattern_ctrl #(
    .N_LEDS(4), .DEB_CYCLES(4), .STEP_CYCLES(16), .KEY_ACTIVE_LOW(1), .LED_ACTIVE_LOW(0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  // Free-running 10 ns clock
  always #5 clk = ~clk;
  // Count cycles spent paused
  always @(negedge clk) if (bus.paused) pcnt++;
  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] rotl(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [3:0] m);
    bit seen = 0;
    bus.key_in = ~m;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = (bus.key_pulse & m) == m;
    end
    check("pulse_seen", 32'(seen), 1);
    @(negedge clk);
    check("pulse_len", 32'(bus.key_pulse & m), 0);
    @(negedge clk);
    bus.key_in = 4'hF;
  endtask
  task automatic settle();
    cycles(10);
  endtask
  task automatic wait_change(output logic [3:0] v, output int dt);
    logic [3:0] prev = bus.led_out;
    bit changed = 0;
    dt = 0;
    while (!changed && dt < 300) begin
      @(negedge clk);
      dt++;
      changed = bus.led_out != prev;
    end
    check("led_change", 32'(changed), 1);
    v = bus.led_out;
  endtask
  initial begin
    logic [3:0] v, e;
    int dt, first, np, p0;
    time t0;
    rst = 1'b1;
    bus.key_in = 4'hF;
    cycles(3);
    check("rst_led", bus.led_out, 4'b0001);
    check("rst_mode", bus.mode, 0);
    check("rst_speed", bus.speed, 0);
    check("rst_paused", bus.paused, 0);
    rst = 1'b0;
    np = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.key_pulse != 0 || bus.led_out != 4'b0001) np++;
    end
    check("idle_hold", np, 0);
    bus.key_in = 4'hE;
    cycles(3);
    bus.key_in = 4'hF;
    np = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.key_pulse[0]) np++;
    end
    check("glitch_pulses", np, 0);
    check("glitch_mode", bus.mode, 0);
    bus.key_in = 4'hE;
    np = 0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.key_pulse[0]) begin
        np++;
        if (first == 0) first = c;
      end
    end
    bus.key_in = 4'hF;
    check("deb_latency", 32'(first >= 6 && first <= 8), 1);
    check("deb_pulses", np, 1);
    check("deb_mode", bus.mode, 1);
    wait_change(v, dt);
    check("shl_first", v, 4'b0010);
    e = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      e = rotl(e);
      wait_change(v, dt);
      check("shl_val", v, e);
      check("shl_dt0", dt, 16);
    end
    check("shl_wrap", v, 4'b0001);
    push(4'b0010); settle();
    push(4'b0010); settle();
    check("speed2", bus.speed, 2);
    wait_change(v, dt);
    for (int k = 0; k < 2; k++) begin
      e = rotl(v);
      wait_change(v, dt);
      check("shl_val2", v, e);
      check("shl_dt2", dt, 4);
    end
    push(4'b0010); settle();
    check("speed3", bus.speed, 3);
    push(4'b0010); settle();
    check("speed_sat", bus.speed, 3);
    wait_change(v, dt);
    wait_change(v, dt);
    check("shl_dt3", dt, 2);
    push(4'b0100); settle();
    push(4'b0100); settle();
    push(4'b0100); settle();
    check("speed_down", bus.speed, 0);
    push(4'b0100); settle();
    check("speed_floor", bus.speed, 0);
    push(4'b0001);
    check("shr_mode", bus.mode, 2);
    check("shr_reload", bus.led_out, 4'b0001);
    wait_change(v, dt);
    check("shr_1", v, 4'b1000);
    check("shr_dt_a", dt, 16);
    wait_change(v, dt);
    check("shr_2", v, 4'b0100);
    check("shr_dt_b", dt, 16);
    push(4'b0001);
    check("blk_mode", bus.mode, 3);
    check("blk_reload", bus.led_out, 4'b1111);
    wait_change(v, dt);
    check("blk_off", v, 4'b0000);
    check("blk_dt_a", dt, 16);
    wait_change(v, dt);
    check("blk_on", v, 4'b1111);
    check("blk_dt_b", dt, 16);
    push(4'b0001);
    check("st_mode", bus.mode, 0);
    check("st_led", bus.led_out, 4'b0001);
    np = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.led_out != 4'b0001) np++;
    end
    check("st_hold", np, 0);
    push(4'b0001);
    check("p_mode", bus.mode, 1);
    wait_change(v, dt);
    check("p_a", v, 4'b0010);
    wait_change(v, dt);
    check("p_b", v, 4'b0100);
    t0 = $time;
    p0 = pcnt;
    push(4'b1000);
    check("paused_on", bus.paused, 1);
    check("paused_led", bus.led_out, 4'b0100);
    np = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.led_out != 4'b0100) np++;
    end
    check("paused_frozen", np, 0);
    check("paused_still", bus.paused, 1);
    push(4'b1000);
    check("paused_off", bus.paused, 0);
    wait_change(v, dt);
    check("resume_val", v, 4'b1000);
    check("resume_active", int'(($time - t0) / 10) - (pcnt - p0), 16);
    settle();
    push(4'b0010); settle();
    check("sim_pre", bus.speed, 1);
    push(4'b0110); settle();
    check("sim_speed", bus.speed, 1);
    push(4'b1001);
    check("sim_mode", bus.mode, 2);
    check("sim_paused", bus.paused, 1);
    check("sim_reload", bus.led_out, 4'b0001);
    settle();
    push(4'b1000);
    wait_change(v, dt);
    check("pre_rst", v, 4'b1000);
    settle();
    #3 rst = 1'b1;
    #1;
    check("arst_led", bus.led_out, 4'b0001);
    check("arst_mode", bus.mode, 0);
    check("arst_speed", bus.speed, 0);
    check("arst_paused", bus.paused, 0);
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.led_out != 4'b0001 || bus.mode != 0 || bus.key_pulse != 0) np++;
    end
    check("post_rst_hold", np, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
